video_timing_gen: RTL

//  Free-running raster timing source on the pixel clock. Produces sync/blank flags (hve) and

---
 rtl/video_timing_pkg.sv | 28 ++
 rtl/video_timing_gen_axis.sv | 38 +++
 rtl/video_timing_gen.sv | 64 ++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared raster constants, hve bit layout and standard video modes
package video_timing_pkg;
  localparam int COORD_W = 13;
  localparam int HVE_HS = 2;
  localparam int HVE_VS = 1;
  localparam int HVE_DE = 0;
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;
  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
    bit hs_pol;
    bit vs_pol;
  } video_mode_t;
  localparam video_mode_t MODE_1280X1024 = '{
    h: '{1280, 48, 112, 248}, v: '{1024, 1, 3, 38}, hs_pol: 1'b1, vs_pol: 1'b1};
  localparam video_mode_t MODE_1280X720 = '{
    h: '{1280, 110, 40, 220}, v: '{720, 5, 5, 20}, hs_pol: 1'b1, vs_pol: 1'b1};
  localparam video_mode_t MODE_640X480 = '{
    h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}, hs_pol: 1'b0, vs_pol: 1'b0};
  function automatic int axis_total(axis_timing_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction
endpackage

// File: rtl/video_timing_gen_axis.sv
// raster_axis_counter: one raster axis; registered signed coordinate plus next-state sync/active flags
module raster_axis_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 1280,
  parameter int FP     = 48,
  parameter int SYNC   = 112,
  parameter int BP     = 248,
  parameter bit POL    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  output logic [COORD_W-1:0] coord,
  output logic               sync,
  output logic               active,
  output logic               wrap
);
  localparam int BLANK = FP + SYNC + BP;
  localparam logic signed [COORD_W-1:0] FIRST   = COORD_W'(-BLANK);
  localparam logic signed [COORD_W-1:0] LAST    = COORD_W'(ACTIVE - 1);
  localparam logic signed [COORD_W-1:0] SYNC_LO = COORD_W'(FP - BLANK);
  localparam logic signed [COORD_W-1:0] SYNC_HI = COORD_W'(FP + SYNC - 1 - BLANK);
  if (ACTIVE + BLANK > 4095 || ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_params
    $error("raster_axis_counter: illegal timing ACTIVE=%0d FP=%0d SYNC=%0d BP=%0d", ACTIVE, FP, SYNC, BP);
  end
  logic signed [COORD_W-1:0] coord_d, coord_q;
  logic in_sync;
  always_comb begin
    wrap    = advance && coord_q == LAST;
    coord_d = (reset || wrap) ? FIRST : advance ? coord_q + COORD_W'(1) : coord_q;
    in_sync = coord_d >= SYNC_LO && coord_d <= SYNC_HI;
    sync    = in_sync ? POL : ~POL;
    active  = ~coord_d[COORD_W-1];
  end
  always_ff @(posedge clk) coord_q <= coord_d;
  assign coord = coord_q;
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running raster timing source with registered hve, coordinates, start pulses and frame count
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = MODE_1280X1024.h.active,
  parameter int H_FP     = MODE_1280X1024.h.fp,
  parameter int H_SYNC   = MODE_1280X1024.h.sync,
  parameter int H_BP     = MODE_1280X1024.h.bp,
  parameter int V_ACTIVE = MODE_1280X1024.v.active,
  parameter int V_FP     = MODE_1280X1024.v.fp,
  parameter int V_SYNC   = MODE_1280X1024.v.sync,
  parameter int V_BP     = MODE_1280X1024.v.bp,
  parameter bit HS_POL   = MODE_1280X1024.hs_pol,
  parameter bit VS_POL   = MODE_1280X1024.vs_pol
) (
  input  logic               hdmi_clk,
  input  logic               reset,
  output logic [2:0]         o_hve,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic [15:0]        o_frame_count
);
  logic run_d, run_q;
  logic h_sync, h_active, h_wrap;
  logic v_sync, v_active, v_wrap;
  logic line_start_d, line_start_q, frame_start_d, frame_start_q;
  logic [2:0] hve_d, hve_q;
  logic [15:0] frame_count_d, frame_count_q;
  raster_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h (
    .clk(hdmi_clk), .reset(reset), .advance(run_q),
    .coord(o_x), .sync(h_sync), .active(h_active), .wrap(h_wrap)
  );
  raster_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v (
    .clk(hdmi_clk), .reset(reset), .advance(h_wrap),
    .coord(o_y), .sync(v_sync), .active(v_active), .wrap(v_wrap)
  );
  always_comb begin
    run_d         = ~reset;
    line_start_d  = ~reset & (h_wrap | ~run_q);
    frame_start_d = ~reset & (v_wrap | ~run_q);
    frame_count_d = reset ? 16'd0 : frame_count_q + 16'(v_wrap);
    hve_d         = '0;
    hve_d[HVE_HS] = h_sync;
    hve_d[HVE_VS] = v_sync;
    hve_d[HVE_DE] = h_active & v_active;
  end
  always_ff @(posedge hdmi_clk) begin
    run_q         <= run_d;
    line_start_q  <= line_start_d;
    frame_start_q <= frame_start_d;
    frame_count_q <= frame_count_d;
    hve_q         <= hve_d;
  end
  assign o_hve         = hve_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_count = frame_count_q;
endmodule
